// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial pattern-scan controller.
//   state_t       : controller FSM states
//   DEF_RST_PAT   : pattern loaded at reset (default configuration)
//   cnt_width()   : width needed to hold a match count of 0..word_w
package seq_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] DEF_RST_PAT = 4'b1101;

    function automatic int unsigned cnt_width(input int unsigned word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/seq_scan_det.sv
// Serial pattern detector.
// Shifts one bit per enabled cycle into a PAT_W-1 bit history and flags a
// hit when the history plus the current bit equals the stored pattern.
// A fill counter suppresses hits until PAT_W bits of the word have been seen.
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear history and fill counter (start of a new word)
//   en         : a bit is presented this cycle
//   bit_in     : current serial bit
//   pat        : pattern to compare against
//   hit        : combinational match pulse for the current bit
module seq_det #(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pat,
    output logic             hit
);

    localparam int unsigned FILL_W = $clog2(PAT_W);

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;
    logic              full;

    // Window = last PAT_W bits including the one presented this cycle.
    assign window = {hist, bit_in};
    assign full   = (fill == FILL_W'(PAT_W - 1));
    assign hit    = en && full && (window == pat);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= window[PAT_W-2:0];
            if (!full) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-parallel in, count out pattern scanner.
// Accepts a WORD_W-bit word in IDLE, streams it MSB first through seq_det
// over WORD_W SHIFT cycles, then holds the match count in DONE until the
// consumer takes it.
//   clk, reset          : clock, synchronous active-high reset
//   cfg_we, cfg_pat     : pattern write (honoured in IDLE only)
//   in_valid, in_ready  : input word handshake, in_data is the word
//   out_valid,out_ready : result handshake, out_count is the match count
//   busy                : high while a word is in flight (SHIFT or DONE)
//   det_hit             : per-cycle detector match pulse
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned      WORD_W  = 16,
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
    localparam int unsigned     CNT_W   = cnt_width(WORD_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              busy,
    output logic              det_hit
);

    state_t              state;
    state_t              state_nxt;
    logic [WORD_W-1:0]   sreg;
    logic [CNT_W-1:0]    idx;
    logic [CNT_W-1:0]    cnt;
    logic [PAT_W-1:0]    pat;
    logic                accept;
    logic                last_bit;

    assign accept   = (state == S_IDLE) && in_valid;
    assign last_bit = (idx == CNT_W'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pattern register is written in IDLE alongside the accept, so a pattern
    // written together with in_valid is already in place for the first bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            idx  <= '0;
            cnt  <= '0;
            pat  <= RST_PAT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        pat <= cfg_pat;
                    end
                    if (in_valid) begin
                        sreg <= in_data;
                        idx  <= '0;
                        cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    sreg <= {sreg[WORD_W-2:0], 1'b0};
                    idx  <= idx + CNT_W'(1);
                    if (det_hit) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_count = cnt;

    seq_det #(
        .PAT_W(PAT_W)
    ) u_det (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (state == S_SHIFT),
        .bit_in (sreg[WORD_W-1]),
        .pat    (pat),
        .hit    (det_hit)
    );

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 16, giving the parallel input word width in bits.
REQ-002 SHALL have parameter PAT_W, default 4, giving the detected pattern width in bits (2..WORD_W).
REQ-003 SHALL have parameter RST_PAT, default 4'b1101, giving the pattern value loaded at reset.
REQ-004 SHALL derive localparam CNT_W = $clog2(WORD_W+1), the match-count width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  reset; synchronous and active-high.
REQ-007 cfg_we  input  1  pattern write strobe.
REQ-008 cfg_pat  input  PAT_W  new pattern value.
REQ-009 in_valid  input  1  input word offered.
REQ-010 in_ready  output  1  block can accept a word.
REQ-011 in_data  input  WORD_W  word to scan, MSB first.
REQ-012 out_valid  output  1  match count available.
REQ-013 out_ready  input  1  consumer accepts the count.
REQ-014 out_count  output  CNT_W  number of pattern matches in the word.
REQ-015 busy  output  1  high in SHIFT or DONE.
REQ-016 det_hit  output  1  per-cycle match pulse from the detector (debug).

Function
REQ-017 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-018 IDLE: in_ready=1; on in_valid, load in_data into the shift register, clear the bit index, count and detector history, and go to SHIFT.
REQ-019 SHIFT: each cycle present the shift-register MSB to the detector, shift left by one, and increment the bit index; after exactly WORD_W SHIFT cycles go to DONE.
REQ-020 Detector: det_hit=1 when at least PAT_W bits of the current word have been seen and the last PAT_W bits, including the current bit, equal the stored pattern; overlapping matches SHALL count.
REQ-021 The count SHALL increment in the same cycle det_hit is high; it never wraps, since the maximum is WORD_W-PAT_W+1.
REQ-022 DONE: out_valid=1 and out_count held stable until out_ready=1; on out_ready, return to IDLE in the next cycle.
REQ-023 Latency: out_valid SHALL first assert WORD_W+1 cycles after the accepting edge.
REQ-024 in_ready SHALL be 0 in SHIFT and DONE; words offered there are not consumed.
REQ-025 cfg_we SHALL update the pattern only in IDLE and is ignored otherwise.
REQ-026 If cfg_we and in_valid are both high in IDLE, the new pattern SHALL apply to the word accepted in that cycle.
REQ-027 Detector history SHALL NOT carry across words: no match spans a word boundary.
REQ-028 out_count SHALL be a registered output; in_ready, out_valid and busy SHALL decode from state.

Reset
REQ-029 On reset: state=IDLE, in_ready=1, out_valid=0, busy=0, det_hit=0, out_count=0, pattern=RST_PAT, shift register, index and history cleared.
REQ-030 Reset asserted mid-SHIFT or mid-DONE SHALL abort the word; no partial count is ever presented.

Structure
REQ-031 State encoding typedef, RST_PAT default and CNT_W helper SHALL live in shared package seq_scan_pkg.
REQ-032 The detector (history register, fill counter, compare) SHALL be sub-module seq_det with ports clk, reset, clr, en, bit_in, pat, hit.
REQ-033 seq_scan_ctrl SHALL hold the FSM, shift register, bit index, count and pattern register.

Verification
REQ-034 Pattern 1101, word 16'hDDDD -> out_valid at cycle 17 after accept, out_count=4.
REQ-035 Pattern written 1111 via cfg_we, word 16'hFFFF -> out_count=13 (overlap); word 16'h0000 -> out_count=0.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_count stable, in_ready=0, a second in_valid is not accepted; accepted after return to IDLE.
REQ-037 cfg_we=1 with 0000 during SHIFT -> ignored, current result unchanged; next word uses the old pattern.
REQ-038 Word 16'h000D then 16'hD000 with pattern 1101 -> counts 1 and 1 (no cross-word match).
REQ-039 reset pulsed at SHIFT cycle 8 -> next cycle IDLE, in_ready=1, out_valid=0, out_count=0, pattern=RST_PAT.
